// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding, state_dbg codes and counter sizing for the PLL reset sequencer
package pll_seq_pkg;
  localparam logic [2:0] ST_RESET_PLL = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABLE    = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_FAULT     = 3'd4;
  typedef enum logic [2:0] {
    RESET_PLL = ST_RESET_PLL,
    WAIT_LOCK = ST_WAIT_LOCK,
    STABLE    = ST_STABLE,
    RUN       = ST_RUN,
    FAULT     = ST_FAULT
  } state_t;
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = (a > b) ? a : b;
    m = (c > m) ? c : m;
    m = (d > m) ? d : m;
    return $clog2(m) + 1;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic 2-flop single-bit synchronizer with synchronous active-high reset
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  always_ff @(posedge clk) begin
    if (rst) {q_o, meta_q} <= 2'b00;
    else     {q_o, meta_q} <= {meta_q, d_i};
  end
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: brings the PLL out of reset, qualifies lock, retries, and latches a fault.
// Define PLL_SEQ_STATUS_EN to add the lock_loss_cnt and state_dbg status outputs.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                               refclk,
  input  logic                               rst,
  input  logic                               pll_locked,
  input  logic                               restart,
  output logic                               pll_rst,
  output logic                               sys_rst_req,
  output logic                               ready,
  output logic                               fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt
`ifdef PLL_SEQ_STATUS_EN
  ,
  output logic [15:0]                        lock_loss_cnt,
  output logic [2:0]                         state_dbg
`endif
);
  localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, MAX_RETRIES);
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] ST_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRIES - 1);
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   retry_d;
  logic            lock_s, fail;
  sync_2ff u_sync (
    .clk (refclk),
    .rst (rst),
    .d_i (pll_locked),
    .q_o (lock_s)
  );
  always_comb begin
    state_d = state_q;
    retry_d = retry_cnt;
    fail    = 1'b0;
    unique case (state_q)
      RESET_PLL: state_d = (cnt_q == RST_LAST) ? WAIT_LOCK : RESET_PLL;
      WAIT_LOCK: begin
        state_d = lock_s ? STABLE : WAIT_LOCK;
        fail    = !lock_s && cnt_q == TO_LAST;
      end
      STABLE: begin
        fail = !lock_s;
        if (lock_s && cnt_q == ST_LAST) begin
          state_d = RUN;
          retry_d = '0;
        end
      end
      RUN: state_d = lock_s ? RUN : RESET_PLL;
      FAULT: if (restart) begin
        state_d = RESET_PLL;
        retry_d = '0;
      end
      default: state_d = RESET_PLL;
    endcase
    if (fail) begin
      state_d = (retry_cnt == RETRY_LAST) ? FAULT : RESET_PLL;
      retry_d = retry_cnt + RW'(1);
    end
    // every transition targets a different state, so a change marks a state entry
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CW'(!(&cnt_q));
  end
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= RESET_PLL;
      cnt_q       <= '0;
      retry_cnt   <= '0;
      pll_rst     <= 1'b1;
      sys_rst_req <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_cnt   <= retry_d;
      pll_rst     <= state_d == RESET_PLL || state_d == FAULT;
      sys_rst_req <= state_d != RUN;
      ready       <= state_d == RUN;
      fault       <= state_d == FAULT;
    end
  end
`ifdef PLL_SEQ_STATUS_EN
  logic [15:0] loss_q;
  always_ff @(posedge refclk) begin
    if (rst) loss_q <= '0;
    else if (state_q == RUN && state_d == RESET_PLL && !(&loss_q)) loss_q <= loss_q + 16'd1;
  end
  assign lock_loss_cnt = loss_q;
  assign state_dbg     = 3'(state_q);
`endif
endmodule
